// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared types and constants for the RV32I fetch-stage program-counter
// generator (pc_gen) and its testbench.
//   redirect_kind_e : encoding of the redirect_kind input
//   pc_state_e      : pc_gen control states
//   INSTR_BYTES     : sequential PC increment (no compressed instructions)
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [1:0] {
        BRANCH = 2'd0,
        JAL    = 2'd1,
        JALR   = 2'd2,
        TRAP   = 2'd3
    } redirect_kind_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        HALT = 2'd3
    } pc_state_e;

    localparam int INSTR_BYTES = 4;

endpackage

// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if
// Instruction-memory request channel between pc_gen and the imem port.
//   req_valid : fetch request valid        (master -> slave)
//   req_addr  : fetch address (= pc)       (master -> slave)
//   req_ready : memory accepts the request (slave  -> master)
// ---------------------------------------------------------------------------
interface pc_gen_if #(
    parameter int ADDRESS = 32
) ();

    logic               req_valid;
    logic               req_ready;
    logic [ADDRESS-1:0] req_addr;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready
    );

endinterface

// File: rtl/pc_hist_shift.sv
// ---------------------------------------------------------------------------
// pc_hist_shift
// History of previous program-counter values. On every i_shift the current
// value on i_din enters entry 0 and older entries move one place deeper.
//   clk, rst  : clock, synchronous active-high reset (clears all entries)
//   i_shift   : shift enable
//   i_din     : value entering entry 0
//   o_hist    : history, [0] is the most recent
// ---------------------------------------------------------------------------
module pc_hist_shift #(
    parameter int ADDRESS    = 32,
    parameter int HIST_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_shift,
    input  logic [ADDRESS-1:0]                   i_din,
    output logic [HIST_DEPTH-1:0][ADDRESS-1:0]   o_hist
);

    logic [HIST_DEPTH-1:0][ADDRESS-1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
        end else if (i_shift) begin
            r_hist[0] <= i_din;
            for (int k = 1; k < HIST_DEPTH; k++) begin
                r_hist[k] <= r_hist[k-1];
            end
        end
    end

    assign o_hist = r_hist;

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Program-counter generator for the RV32I fetch stage. Presents fetch
// requests to instruction memory with a valid/ready handshake, applies
// prioritised redirects (branch, jal, jalr, trap), detects misaligned
// targets (entering HALT) and keeps a history of previous PCs.
//   clk, rst           : clock, synchronous active-high reset
//   i_stall            : hold off raising a new fetch request
//   i_redirect_valid   : redirect request this cycle
//   i_redirect_kind    : BRANCH / JAL / JALR / TRAP
//   i_branch_taken     : qualifies BRANCH redirects
//   i_redirect_target  : requested new PC
//   imem               : fetch request channel (master side)
//   o_pc               : current PC
//   o_pc_hist          : previous PCs, [0] is the most recent
//   o_misalign_valid   : one-cycle pulse after a misaligned redirect
//   o_misalign_addr    : offending target, held until the next misalign
// ---------------------------------------------------------------------------
module pc_gen
    import pc_pkg::*;
#(
    parameter int                 ADDRESS      = 32,
    parameter logic [ADDRESS-1:0] RESET_VECTOR = '0,
    parameter int                 HIST_DEPTH   = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_stall,
    input  logic                                 i_redirect_valid,
    input  redirect_kind_e                       i_redirect_kind,
    input  logic                                 i_branch_taken,
    input  logic [ADDRESS-1:0]                   i_redirect_target,
    pc_gen_if.master                             imem,
    output logic [ADDRESS-1:0]                   o_pc,
    output logic [HIST_DEPTH-1:0][ADDRESS-1:0]   o_pc_hist,
    output logic                                 o_misalign_valid,
    output logic [ADDRESS-1:0]                   o_misalign_addr
);

    // JALR drops bit 0, TRAP vectors are word aligned, others pass through.
    function automatic logic [ADDRESS-1:0] form_target(
        input redirect_kind_e     kind,
        input logic [ADDRESS-1:0] target
    );
        logic [ADDRESS-1:0] t;
        t = target;
        if (kind == JALR) t[0] = 1'b0;
        if (kind == TRAP) t[1:0] = 2'b00;
        return t;
    endfunction

    pc_state_e          r_state;
    logic [ADDRESS-1:0] r_pc;
    logic               r_req_valid;
    logic [ADDRESS-1:0] r_pend_target;
    logic               r_misalign_valid;
    logic [ADDRESS-1:0] r_misalign_addr;

    pc_state_e          w_next_state;
    logic [ADDRESS-1:0] w_next_pc;
    logic               w_next_req_valid;
    logic [ADDRESS-1:0] w_next_pend;
    logic               w_set_misalign;
    logic               w_load_pc;

    logic               w_accept;
    logic               w_effective;
    logic               w_trap;
    logic               w_redirect;
    logic               w_misalign;
    logic [ADDRESS-1:0] w_target;

    assign w_accept    = r_req_valid && imem.req_ready;
    assign w_effective = i_redirect_valid && ((i_redirect_kind != BRANCH) || i_branch_taken);
    assign w_trap      = w_effective && (i_redirect_kind == TRAP);
    // Non-trap redirect; misaligned ones are caught ahead of it in priority.
    assign w_redirect  = w_effective && (i_redirect_kind != TRAP);
    assign w_target    = form_target(i_redirect_kind, i_redirect_target);
    assign w_misalign  = w_redirect && w_target[1];

    always_comb begin
        w_next_state     = r_state;
        w_next_pc        = r_pc;
        w_next_req_valid = r_req_valid;
        w_next_pend      = r_pend_target;
        w_set_misalign   = 1'b0;
        w_load_pc        = 1'b0;

        if (w_trap) begin
            // Trap overrides everything, including an unaccepted request.
            w_next_state     = RUN;
            w_next_pc        = w_target;
            w_load_pc        = 1'b1;
            w_next_req_valid = !i_stall;
            w_next_pend      = '0;
        end else if (r_state == HALT) begin
            w_next_req_valid = 1'b0;
        end else if (w_misalign) begin
            w_set_misalign   = 1'b1;
            w_next_state     = HALT;
            w_next_req_valid = 1'b0;
        end else if (r_state == PEND) begin
            if (w_accept) begin
                // A redirect arriving on the accepting cycle is the newest target.
                w_next_pc        = w_redirect ? w_target : r_pend_target;
                w_load_pc        = 1'b1;
                w_next_state     = RUN;
                w_next_req_valid = !i_stall;
            end else if (w_redirect) begin
                w_next_pend = w_target;
            end
        end else begin
            // BOOT and RUN: BOOT never has a request outstanding.
            w_next_state = RUN;
            if (w_redirect) begin
                if (r_req_valid && !imem.req_ready) begin
                    w_next_pend  = w_target;
                    w_next_state = PEND;
                end else begin
                    w_next_pc        = w_target;
                    w_load_pc        = 1'b1;
                    w_next_req_valid = !i_stall;
                end
            end else if (w_accept) begin
                w_next_pc        = r_pc + ADDRESS'(INSTR_BYTES);
                w_load_pc        = 1'b1;
                w_next_req_valid = !i_stall;
            end else if (!r_req_valid) begin
                w_next_req_valid = !i_stall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= BOOT;
            r_pc             <= RESET_VECTOR;
            r_req_valid      <= 1'b0;
            r_pend_target    <= '0;
            r_misalign_valid <= 1'b0;
            r_misalign_addr  <= '0;
        end else begin
            r_state          <= w_next_state;
            r_pc             <= w_next_pc;
            r_req_valid      <= w_next_req_valid;
            r_pend_target    <= w_next_pend;
            r_misalign_valid <= w_set_misalign;
            if (w_set_misalign) begin
                r_misalign_addr <= w_target;
            end
        end
    end

    pc_hist_shift #(
        .ADDRESS    (ADDRESS),
        .HIST_DEPTH (HIST_DEPTH)
    ) u_hist (
        .clk     (clk),
        .rst     (rst),
        .i_shift (w_load_pc),
        .i_din   (r_pc),
        .o_hist  (o_pc_hist)
    );

    assign o_pc             = r_pc;
    assign imem.req_valid   = r_req_valid;
    assign imem.req_addr    = r_pc;
    assign o_misalign_valid = r_misalign_valid;
    assign o_misalign_addr  = r_misalign_addr;

endmodule
